mac_bus_ctrl: RTL and testbench
===============================

# mac_bus_ctrl

Bus-cycle responder that sits directly downstream of the 68000-compatible CPU bus wrapper. It decodes each asynchronous CPU bus cycle (AS/UDS/LDS/RW/FC/address) in the Mac Plus memory map and returns the matching handshake: DTACK for memory and device cycles, VPA for VIA and autovectored interrupt-acknowledge cycles, or BERR on timeout. It converts cycles into a single-outstanding req/ack transaction toward the memory controller or the I/O devices, and latches read data for the CPU.

## Interface
- DTACK_TIMEOUT, 255: phi2 pulses a cycle may wait for ack before BERR (8-bit counter).
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- phi1, phi2  in  1  CPU phase enables, one-clk pulses, never coincident.
- overlay  in  1  1 = ROM mirrored at 0x000000–0x0FFFFF.
- as_n, uds_n, lds_n, rw_n  in  1  CPU bus strobes.
- fc  in  3  CPU function code.
- addr  in  24  CPU byte address; bit 0 ignored.
- cpu_dout  in  16  CPU write data.
- cpu_din  out  16  read data to CPU; reset 0.
- dtack_n, vpa_n  out  1  reset 1.
- berr  out  1  reset 0.
- vma_n  in  1  valid-memory-address from the CPU wrapper.
- mem_req  out  1  RAM/ROM request, level; reset 0.
- mem_we  out  1  write when 1; reset 0.
- mem_addr  out  24  translated address; reset 0.
- mem_be  out  2  {upper, lower} byte enables; reset 0.
- mem_wdata  out  16  write data; reset 0.
- mem_rdata  in  16  read data, valid with mem_ack.
- mem_ack  in  1  one-clk completion pulse.
- dev_req  out  1  I/O request, level; reset 0.
- dev_sel  out  2  0 = SCC, 1 = IWM, 2 = VIA; reset 0.
- dev_rdata  in  16  device read data, valid with dev_ack.
- dev_ack  in  1  one-clk completion pulse.

## Operation
- Decode on cycle start (addr[23:20]): 0x0–0x3 RAM (ROM if overlay and addr < 0x100000); 0x4 ROM, mem_addr = {4'h4, addr[19:0]}; 0x9/0xB SCC; 0xD IWM; 0xE with addr[19] = 1 VIA; fc = 3'b111 IACK; anything else is unmapped.
- Cycle start: as_n = 0 in IDLE, plus, for writes, (uds_n & lds_n) = 0. Write strobes trail AS, so a write is not started until a strobe is low.
- States: IDLE, MEM_WAIT, DEV_WAIT, VPA_WAIT, VIA_WAIT, ACK, BERR.
- IDLE → MEM_WAIT (RAM/ROM), DEV_WAIT (SCC/IWM), VPA_WAIT (VIA/IACK), BERR (unmapped).
- On entry to MEM_WAIT/DEV_WAIT: req = 1, we = ~rw_n, be = {~uds_n, ~lds_n}, wdata = cpu_dout, addr latched.
- MEM_WAIT/DEV_WAIT on ack: req = 0, cpu_din = rdata when reading, go to ACK.
- ACK: dtack_n = 0. Hold until as_n = 1, then dtack_n = 1 and go to IDLE.
- VPA_WAIT: vpa_n = 0 from entry.
  - IACK: no request. Return to IDLE when as_n = 1.
  - VIA: on the first vma_n = 0, dev_req = 1 with dev_sel = 2 and go to VIA_WAIT. On dev_ack, latch data and drop req. vpa_n stays 0 until as_n = 1.
- Timeout: 8-bit counter clears on cycle start and increments on phi2 in MEM_WAIT, DEV_WAIT, VPA_WAIT and VIA_WAIT.
  - If it reaches DTACK_TIMEOUT: drop req, set berr = 1, go to BERR.
  - Unmapped cycles enter BERR directly.
  - BERR holds berr = 1 until as_n = 1, then berr = 0 and go to IDLE.
- as_n rising in any wait state (CPU abort): drop req, ignore a later ack, go to IDLE. The memory side tolerates a dropped req.
- Only one request is outstanding at a time, and mem_req and dev_req are never both 1.

## Timing
- Request asserted 1 clk after the start condition is sampled.
- dtack_n falls 1 clk after the ack pulse.
- cpu_din is valid on the same edge that dtack_n falls and is stable until the next cycle start.
- dtack_n, vpa_n and berr rise 1 clk after as_n = 1 is sampled.
- dev_ack for VIA must arrive within 4 clk of dev_req, ahead of the CPU's E-synchronous data sample.
- Reset mid-cycle: all outputs take their reset values on the next clk and the state returns to IDLE. An ack arriving after reset is ignored.
- An ack on the same clk as as_n rising: the ack is discarded and no dtack is issued.

## Test plan
- RAM read: as_n = 0, rw_n = 1, addr = 0x001234, overlay = 0, mem_ack after 3 clk with 0xBEEF → mem_addr = 0x001234, be = 2'b11; dtack_n = 0 one clk after ack; cpu_din = 0xBEEF; dtack_n = 1 after as_n rises.
- Overlay and byte write: overlay = 1, write 0x55 to addr 0x000101 (lds only) → no request until lds_n = 0; then mem_addr = 0x400100, be = 2'b01, we = 1, wdata = cpu_dout.
- VIA read: addr = 0xEFE1FE → vpa_n = 0 and no dev_req until vma_n = 0; then dev_sel = 2; dev_ack with 0x00A5 → cpu_din = 0x00A5; dtack_n stays 1 throughout.
- IACK: fc = 3'b111, addr = 0xFFFFF5 → vpa_n = 0, no request issued, released after as_n = 1.
- Timeout and unmapped: RAM read with no ack and DTACK_TIMEOUT = 8 → berr = 1 after 8 phi2 pulses and mem_req = 0. Read at 0x600000 → berr immediately, no request.
- Abort and reset: as_n rises during MEM_WAIT, then a late mem_ack arrives → no dtack. Reset asserted in DEV_WAIT → dev_req = 0 next clk and all outputs at reset values.

Source files
------------

// File: rtl/mac_bus_ctrl.sv
// Mac Plus bus-cycle responder: decodes 68000 bus cycles, issues single-outstanding
// req/ack transactions to memory or I/O, and returns DTACK, VPA or BERR to the CPU.
module mac_bus_ctrl #(
    parameter int DTACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phi1,
    input  logic        phi2,
    input  logic        overlay,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        rw_n,
    input  logic [2:0]  fc,
    input  logic [23:0] addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr,
    input  logic        vma_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        dev_req,
    output logic [1:0]  dev_sel,
    input  logic [15:0] dev_rdata,
    input  logic        dev_ack
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_WAIT,
        DEV_WAIT,
        VPA_WAIT,
        VIA_WAIT,
        ACK,
        BERR
    } state_t;

    localparam logic [8:0] TMO_LIMIT = 9'(DTACK_TIMEOUT);
    localparam logic [1:0] SEL_SCC   = 2'd0;
    localparam logic [1:0] SEL_IWM   = 2'd1;
    localparam logic [1:0] SEL_VIA   = 2'd2;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        iack_q, iack_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        dev_req_q, dev_req_d;
    logic [1:0]  dev_sel_q, dev_sel_d;
    logic [15:0] cpu_din_q, cpu_din_d;
    logic        dtack_n_q, dtack_n_d;
    logic        vpa_n_q, vpa_n_d;
    logic        berr_q, berr_d;

    // phi1 and the byte-select address bit carry no information for this block.
    logic unused_inputs;
    assign unused_inputs = ^{phi1, addr[0]};

    logic [3:0]  region;
    logic        is_iack, is_ram, is_rom, is_ovl_rom, is_scc, is_iwm, is_via;
    logic        cycle_start;
    logic [23:0] ram_addr, rom_addr;
    logic [8:0]  cnt_inc;
    logic        tmo_hit;

    assign region      = addr[23:20];
    assign is_iack     = (fc == 3'b111);
    assign is_ram      = (region[3:2] == 2'b00);
    assign is_ovl_rom  = overlay && (region == 4'h0);
    assign is_rom      = (region == 4'h4);
    assign is_scc      = (region == 4'h9) || (region == 4'hB);
    assign is_iwm      = (region == 4'hD);
    assign is_via      = (region == 4'hE) && addr[19];
    assign ram_addr    = {addr[23:1], 1'b0};
    assign rom_addr    = {4'h4, addr[19:1], 1'b0};

    // Write strobes trail AS, so a write only starts once a data strobe is low.
    assign cycle_start = !as_n && (rw_n || !(uds_n && lds_n));

    assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
    assign tmo_hit     = phi2 && (cnt_inc == TMO_LIMIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        iack_d      = iack_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        dev_req_d   = dev_req_q;
        dev_sel_d   = dev_sel_q;
        cpu_din_d   = cpu_din_q;
        dtack_n_d   = dtack_n_q;
        vpa_n_d     = vpa_n_q;
        berr_d      = berr_q;

        case (state_q)
            IDLE: begin
                if (cycle_start) begin
                    cnt_d  = 8'd0;
                    iack_d = is_iack;
                    if (is_iack || is_via) begin
                        vpa_n_d = 1'b0;
                        state_d = VPA_WAIT;
                    end else if (is_ram || is_rom) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = !rw_n;
                        mem_be_d    = {!uds_n, !lds_n};
                        mem_wdata_d = cpu_dout;
                        mem_addr_d  = (is_rom || is_ovl_rom) ? rom_addr : ram_addr;
                        state_d     = MEM_WAIT;
                    end else if (is_scc || is_iwm) begin
                        dev_req_d   = 1'b1;
                        dev_sel_d   = is_iwm ? SEL_IWM : SEL_SCC;
                        mem_we_d    = !rw_n;
                        mem_be_d    = {!uds_n, !lds_n};
                        mem_wdata_d = cpu_dout;
                        mem_addr_d  = ram_addr;
                        state_d     = DEV_WAIT;
                    end else begin
                        berr_d  = 1'b1;
                        state_d = BERR;
                    end
                end
            end

            // An ack sampled together with as_n high is dropped by the abort branch.
            MEM_WAIT: begin
                if (as_n) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_din_d = mem_rdata;
                    end
                    dtack_n_d = 1'b0;
                    state_d   = ACK;
                end else if (phi2) begin
                    cnt_d = cnt_inc[7:0];
                    if (tmo_hit) begin
                        mem_req_d = 1'b0;
                        berr_d    = 1'b1;
                        state_d   = BERR;
                    end
                end
            end

            DEV_WAIT: begin
                if (as_n) begin
                    dev_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (dev_ack) begin
                    dev_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_din_d = dev_rdata;
                    end
                    dtack_n_d = 1'b0;
                    state_d   = ACK;
                end else if (phi2) begin
                    cnt_d = cnt_inc[7:0];
                    if (tmo_hit) begin
                        dev_req_d = 1'b0;
                        berr_d    = 1'b1;
                        state_d   = BERR;
                    end
                end
            end

            VPA_WAIT: begin
                if (as_n) begin
                    vpa_n_d = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    cnt_d   = cnt_inc[7:0];
                    vpa_n_d = 1'b1;
                    berr_d  = 1'b1;
                    state_d = BERR;
                end else begin
                    if (phi2) begin
                        cnt_d = cnt_inc[7:0];
                    end
                    if (!iack_q && !vma_n) begin
                        dev_req_d   = 1'b1;
                        dev_sel_d   = SEL_VIA;
                        mem_we_d    = !rw_n;
                        mem_be_d    = {!uds_n, !lds_n};
                        mem_wdata_d = cpu_dout;
                        mem_addr_d  = ram_addr;
                        state_d     = VIA_WAIT;
                    end
                end
            end

            // The VIA answers with VPA, so the ack only latches data; AS ends the cycle.
            VIA_WAIT: begin
                if (as_n) begin
                    dev_req_d = 1'b0;
                    vpa_n_d   = 1'b1;
                    state_d   = IDLE;
                end else if (dev_req_q && dev_ack) begin
                    dev_req_d = 1'b0;
                    if (!mem_we_q) begin
                        cpu_din_d = dev_rdata;
                    end
                end else if (phi2) begin
                    cnt_d = cnt_inc[7:0];
                    if (tmo_hit) begin
                        dev_req_d = 1'b0;
                        vpa_n_d   = 1'b1;
                        berr_d    = 1'b1;
                        state_d   = BERR;
                    end
                end
            end

            ACK: begin
                if (as_n) begin
                    dtack_n_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            BERR: begin
                if (as_n) begin
                    berr_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            iack_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 24'd0;
            mem_be_q    <= 2'b00;
            mem_wdata_q <= 16'd0;
            dev_req_q   <= 1'b0;
            dev_sel_q   <= 2'd0;
            cpu_din_q   <= 16'd0;
            dtack_n_q   <= 1'b1;
            vpa_n_q     <= 1'b1;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            iack_q      <= iack_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            dev_req_q   <= dev_req_d;
            dev_sel_q   <= dev_sel_d;
            cpu_din_q   <= cpu_din_d;
            dtack_n_q   <= dtack_n_d;
            vpa_n_q     <= vpa_n_d;
            berr_q      <= berr_d;
        end
    end

    assign cpu_din   = cpu_din_q;
    assign dtack_n   = dtack_n_q;
    assign vpa_n     = vpa_n_q;
    assign berr      = berr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign dev_req   = dev_req_q;
    assign dev_sel   = dev_sel_q;

endmodule

// File: tb/tb_mac_bus_ctrl.sv
// Directed and randomized bus-cycle bench for mac_bus_ctrl, checked against a
// memory-map decode model and cycle-level expectations.
module tb_mac_bus_ctrl;

    localparam int K_MEM   = 0;
    localparam int K_DEV   = 1;
    localparam int K_VIA   = 2;
    localparam int K_IACK  = 3;
    localparam int K_UNMAP = 4;
    localparam logic [2:0] FC_DATA = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        phi1, phi2;
    logic        overlay;
    logic        as_n, uds_n, lds_n, rw_n;
    logic [2:0]  fc;
    logic [23:0] addr;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic        dtack_n, vpa_n, berr;
    logic        vma_n;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        dev_req;
    logic [1:0]  dev_sel;
    logic [15:0] dev_rdata;
    logic        dev_ack;

    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_din;

    mac_bus_ctrl #(.DTACK_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .overlay(overlay),
        .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw_n(rw_n), .fc(fc),
        .addr(addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .dtack_n(dtack_n),
        .vpa_n(vpa_n), .berr(berr), .vma_n(vma_n), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dev_req(dev_req), .dev_sel(dev_sel), .dev_rdata(dev_rdata),
        .dev_ack(dev_ack)
    );

    always #5 clk = ~clk;

    // Phase enables change 2 ns after the rising edge, one phi2 every ten clocks.
    initial begin
        int phase = 0;
        phi1 = 1'b0;
        phi2 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            phase = (phase + 1) % 10;
            phi1  = (phase == 0);
            phi2  = (phase == 5);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic as_v, input logic uds_v, input logic lds_v,
                                 input logic rw_v, input logic [2:0] fc_v,
                                 input logic [23:0] a, input logic [15:0] d);
        as_n     = as_v;
        uds_n    = uds_v;
        lds_n    = lds_v;
        rw_n     = rw_v;
        fc       = fc_v;
        addr     = a;
        cpu_dout = d;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_dtack_n"}, dtack_n, 1);
        checkOutput({tag, "_vpa_n"}, vpa_n, 1);
        checkOutput({tag, "_berr"}, berr, 0);
        checkOutput({tag, "_mem_req"}, mem_req, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_be"}, mem_be, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_dev_req"}, dev_req, 0);
        checkOutput({tag, "_dev_sel"}, dev_sel, 0);
        checkOutput({tag, "_cpu_din"}, cpu_din, 0);
    endtask

    // Mac Plus memory map, expressed as address ranges.
    function automatic void modelDecode(input logic [23:0] a, input logic [2:0] f,
                                        input logic ovl, output int kind,
                                        output logic [23:0] xaddr, output logic [1:0] xsel);
        int unsigned region;
        logic [23:0] even;
        region = a / 24'h100000;
        even   = a - (a % 2);
        xaddr  = even;
        xsel   = 2'd0;
        if (f == 3'b111) kind = K_IACK;
        else if (region < 4) begin
            kind = K_MEM;
            if (ovl && a < 24'h100000) xaddr = 24'h400000 + even;
        end else if (region == 4) kind = K_MEM;
        else if (region == 9 || region == 11) kind = K_DEV;
        else if (region == 13) begin
            kind = K_DEV;
            xsel = 2'd1;
        end else if (region == 14 && a >= 24'hE80000) begin
            kind = K_VIA;
            xsel = 2'd2;
        end else kind = K_UNMAP;
    endfunction

    // One complete DTACK-terminated memory or SCC/IWM cycle.
    task automatic memDevCycle(input logic [23:0] a, input logic ovl, input logic rw,
                               input logic [1:0] be, input logic [15:0] wd,
                               input logic [15:0] rd, input int delay, input logic late);
        int          kind;
        logic [23:0] xa;
        logic [1:0]  xs;
        modelDecode(a, FC_DATA, ovl, kind, xa, xs);
        overlay = ovl;
        if (late && !rw) begin
            applyStimulus(1'b0, 1'b1, 1'b1, rw, FC_DATA, a, wd);
            tick();
            tick();
            checkOutput("late_strobe_no_req", {mem_req, dev_req}, 0);
        end
        applyStimulus(1'b0, !be[1], !be[0], rw, FC_DATA, a, wd);
        tick();
        if (kind == K_MEM) begin
            checkOutput("mem_req", {mem_req, dev_req}, 2'b10);
            checkOutput("mem_addr", mem_addr, xa);
        end else begin
            checkOutput("dev_req", {mem_req, dev_req}, 2'b01);
            checkOutput("dev_sel", dev_sel, xs);
        end
        checkOutput("we", mem_we, !rw);
        checkOutput("be", mem_be, be);
        if (!rw) checkOutput("wdata", mem_wdata, wd);
        for (int i = 0; i < delay; i++) begin
            tick();
            checkOutput("dtack_wait", dtack_n, 1);
        end
        if (kind == K_MEM) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
        end else begin
            dev_ack   = 1'b1;
            dev_rdata = rd;
        end
        tick();
        mem_ack = 1'b0;
        dev_ack = 1'b0;
        if (rw) exp_din = rd;
        checkOutput("dtack_low", dtack_n, 0);
        checkOutput("req_dropped", {mem_req, dev_req}, 0);
        checkOutput("cpu_din", cpu_din, exp_din);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, a, wd);
        tick();
        checkOutput("dtack_release", dtack_n, 1);
    endtask

    initial begin
        int          pulses;
        logic        done;
        logic [23:0] a;
        logic [3:0]  rg;
        logic [1:0]  be;
        logic        rw;
        int          kind;
        logic [23:0] xa;
        logic [1:0]  xs;

        reset     = 1'b1;
        overlay   = 1'b0;
        vma_n     = 1'b1;
        mem_ack   = 1'b0;
        dev_ack   = 1'b0;
        mem_rdata = 16'd0;
        dev_rdata = 16'd0;
        exp_din   = 16'd0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, 24'd0, 16'd0);
        tick();
        tick();
        reset = 1'b0;
        checkResetOutputs("reset");

        $display("[TB] RAM read and overlay byte write");
        memDevCycle(24'h001234, 1'b0, 1'b1, 2'b11, 16'h0000, 16'hBEEF, 3, 1'b0);
        memDevCycle(24'h000101, 1'b1, 1'b0, 2'b01, 16'h0055, 16'h1111, 2, 1'b1);
        checkOutput("ovl_rom_addr", mem_addr, 24'h400100);

        $display("[TB] randomized memory and device cycles");
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 7))
                0: rg = 4'h0;
                1: rg = 4'h1;
                2: rg = 4'h2;
                3: rg = 4'h3;
                4: rg = 4'h4;
                5: rg = 4'h9;
                6: rg = 4'hB;
                default: rg = 4'hD;
            endcase
            a  = {rg, 20'($urandom)};
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: be = 2'b01;
                1: be = 2'b10;
                default: be = 2'b11;
            endcase
            memDevCycle(a, 1'($urandom_range(0, 1)), rw, be, 16'($urandom), 16'($urandom),
                        $urandom_range(0, 5), !rw && ($urandom_range(0, 1) == 1));
        end

        $display("[TB] VIA read");
        modelDecode(24'hEFE1FE, FC_DATA, 1'b0, kind, xa, xs);
        checkOutput("via_decode", kind, K_VIA);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, FC_DATA, 24'hEFE1FE, 16'd0);
        tick();
        checkOutput("via_vpa", vpa_n, 0);
        checkOutput("via_no_req", dev_req, 0);
        tick();
        checkOutput("via_no_req2", dev_req, 0);
        vma_n = 1'b0;
        tick();
        checkOutput("via_req", dev_req, 1);
        checkOutput("via_sel", dev_sel, xs);
        dev_ack   = 1'b1;
        dev_rdata = 16'h00A5;
        tick();
        dev_ack = 1'b0;
        exp_din = 16'h00A5;
        checkOutput("via_din", cpu_din, exp_din);
        checkOutput("via_req_drop", dev_req, 0);
        checkOutput("via_vpa_hold", vpa_n, 0);
        checkOutput("via_dtack", dtack_n, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, 24'hEFE1FE, 16'd0);
        vma_n = 1'b1;
        tick();
        checkOutput("via_vpa_release", vpa_n, 1);

        $display("[TB] interrupt acknowledge");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 24'hFFFFF5, 16'd0);
        tick();
        checkOutput("iack_vpa", vpa_n, 0);
        tick();
        checkOutput("iack_no_req", {mem_req, dev_req, berr, dtack_n}, 4'b0001);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, 24'hFFFFF5, 16'd0);
        tick();
        checkOutput("iack_release", vpa_n, 1);

        $display("[TB] timeout and unmapped");
        overlay = 1'b0;
        a = {4'h2, 20'($urandom)};
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, FC_DATA, a, 16'd0);
        tick();
        pulses = 0;
        done   = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            checkOutput("tmo_berr", berr, pulses >= 8);
            checkOutput("tmo_req", mem_req, pulses < 8);
            if (pulses >= 8) done = 1'b1;
            else begin
                if (phi2) pulses++;
                tick();
            end
        end
        checkOutput("tmo_reached", done, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, a, 16'd0);
        tick();
        checkOutput("tmo_berr_release", berr, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, FC_DATA, 24'h600000, 16'd0);
        tick();
        checkOutput("unmap_berr", berr, 1);
        checkOutput("unmap_no_req", {mem_req, dev_req}, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, 24'h600000, 16'd0);
        tick();
        checkOutput("unmap_release", berr, 0);

        $display("[TB] abort and reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, FC_DATA, 24'h012340, 16'd0);
        tick();
        checkOutput("abort_req", mem_req, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, 24'h012340, 16'd0);
        tick();
        checkOutput("abort_req_drop", mem_req, 0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        checkOutput("abort_no_dtack", dtack_n, 1);
        checkOutput("abort_din", cpu_din, exp_din);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, FC_DATA, 24'h012340, 16'd0);
        tick();
        checkOutput("race_req", mem_req, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, 24'h012340, 16'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hCAFE;
        tick();
        mem_ack = 1'b0;
        checkOutput("race_no_dtack", dtack_n, 1);
        checkOutput("race_din", cpu_din, exp_din);
        tick();
        checkOutput("race_no_dtack2", dtack_n, 1);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, FC_DATA, 24'h9FFFF8, 16'd0);
        tick();
        checkOutput("rst_dev_req", dev_req, 1);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, FC_DATA, 24'h9FFFF8, 16'd0);
        tick();
        checkResetOutputs("midreset");
        reset     = 1'b0;
        dev_ack   = 1'b1;
        dev_rdata = 16'h5A5A;
        tick();
        dev_ack = 1'b0;
        checkOutput("post_reset_dtack", dtack_n, 1);
        checkOutput("post_reset_din", cpu_din, 0);
        checkOutput("post_reset_req", dev_req, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
